// File: rtl/input_debounce_sync_if.sv
// Pad-input conditioning bus: raw bytes in, debounced byte plus change
// strobe and optional sticky rising-edge flags out.
interface input_debounce_sync_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] db_out;
  logic             changed;
  logic [WIDTH-1:0] rise_flags;
  logic             clr_flags;

  // Selector side: drives raw pads and controls, consumes the clean byte
  modport master (
    output en, raw_in, clr_flags,
    input  db_out, changed, rise_flags
  );

  // Debouncer side
  modport slave (
    input  en, raw_in, clr_flags,
    output db_out, changed, rise_flags
  );
endinterface

// File: rtl/input_debounce_sync.sv
// input_debounce_sync: 2-flop synchroniser plus per-bit debounce counter.
// db_out only flips after DEBOUNCE_CYCLES consecutive synchronised samples
// disagree with it; a single agreeing sample restarts the count.
// Optional macro INPUT_DEBOUNCE_RISE_FLAGS_EN adds sticky per-bit rising-edge
// flags cleared by clr_flags; without it rise_flags is tied to 0.

// One debounced bit. o_flip is high in the cycle whose rising edge will
// update o_db, so the top can build the change strobe and rise flags.
module input_debounce_sync_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_raw,
  output logic o_db,
  output logic o_flip
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic          w_mismatch;
  logic          w_flip;

  assign w_mismatch = r_sync1 ^ r_db;
  assign w_flip     = i_en & w_mismatch & (r_cnt == CNT_LAST);

  // Synchroniser runs regardless of en; counter clears on en=0, agreement,
  // or the terminal count that commits the new stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      if (!i_en || !w_mismatch || w_flip) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (w_flip) r_db <= r_sync1;
    end
  end

  assign o_db   = r_db;
  assign o_flip = w_flip;
endmodule

module input_debounce_sync #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input_debounce_sync_if.slave  bus
);
  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_flip;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    input_debounce_sync_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (bus.en),
      .i_raw  (bus.raw_in[g]),
      .o_db   (w_db[g]),
      .o_flip (w_flip[g])
    );
  end

  // One strobe per edge no matter how many bits flip together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_changed <= 1'b0;
    else     r_changed <= |w_flip;
  end

  assign bus.db_out  = w_db;
  assign bus.changed = r_changed;

`ifdef INPUT_DEBOUNCE_RISE_FLAGS_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] w_rise_set;

  // A flip while db is currently 0 is a 0->1 transition
  assign w_rise_set = w_flip & ~w_db;

  // Sticky flags; a set on the same edge as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rise <= '0;
    else     r_rise <= (r_rise & ~{WIDTH{bus.clr_flags}}) | w_rise_set;
  end

  assign bus.rise_flags = r_rise;
`else
  logic w_unused_clr;
  assign w_unused_clr   = ^{1'b0, bus.clr_flags};
  assign bus.rise_flags = '0;
`endif
endmodule
